// File: rtl/vita49_pkg.sv
// Shared types and header helpers for the VITA-49 64-bit packetiser.
package vita49_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_PAY
    } state_t;

    localparam logic [3:0] PKT_TYPE = 4'h1;
    localparam logic [1:0] TSI_UTC  = 2'b01;
    localparam logic [1:0] TSF_REAL = 2'b10;

    // Packet size counts 32-bit words: three 64-bit header beats plus payload.
    function automatic logic [31:0] build_hdr(input logic [3:0] pkt_cnt, input logic [15:0] len);
        logic [15:0] size;
        size = (len + 16'd3) << 1;
        return {PKT_TYPE, 2'b00, 2'b00, TSI_UTC, TSF_REAL, pkt_cnt, size};
    endfunction

endpackage

// File: rtl/vita49_ts_latch64.sv
// Two-flop retiming of the timing-unit time plus the per-packet capture register.
module vita49_ts_latch64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tsi,
    input  logic [63:0] tsf,
    input  logic        capture,
    output logic [31:0] tsi_lat,
    output logic [63:0] tsf_lat
);

    logic [31:0] tsi_d1, tsi_d2;
    logic [63:0] tsf_d1, tsf_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tsi_d1  <= '0;
            tsi_d2  <= '0;
            tsf_d1  <= '0;
            tsf_d2  <= '0;
            tsi_lat <= '0;
            tsf_lat <= '0;
        end else begin
            tsi_d1 <= tsi;
            tsi_d2 <= tsi_d1;
            tsf_d1 <= tsf;
            tsf_d2 <= tsf_d1;
            if (capture) begin
                tsi_lat <= tsi_d2;
                tsf_lat <= tsf_d2;
            end
        end
    end

endmodule

// File: rtl/vita49_pack64_logic.sv
// Frames a raw 64-bit AXIS sample stream into VITA-49 IF-data packets
// (three header beats, then pkt_len payload beats passed straight through).
module vita49_pack64_logic
    import vita49_pkg::*;
#(
    parameter int C_AXIS_TDATA_NUM_BYTES = 8,
    parameter int C_LEN_W                = 12
) (
    input  logic                                AXIS_ACLK,
    input  logic                                AXIS_ARESETN,
    input  logic [C_AXIS_TDATA_NUM_BYTES*8-1:0] S_AXIS_TDATA,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    output logic [C_AXIS_TDATA_NUM_BYTES*8-1:0] M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    input  logic [31:0]                         ctrl,
    input  logic [C_LEN_W-1:0]                  pkt_len,
    input  logic [31:0]                         stream_id,
    output logic [31:0]                         status,
    input  logic [31:0]                         tsi,
    input  logic [63:0]                         tsf
);

    state_t             state, state_nxt;
    logic [2:0]         ctrl_r;
    logic [C_LEN_W-1:0] len_r, len_lat, beat_cnt;
    logic [31:0]        sid_r, sid_lat;
    logic [31:0]        tsi_lat;
    logic [63:0]        tsf_lat;
    logic [3:0]         pkt_cnt;
    logic [15:0]        sent_cnt;
    logic               soft_pend, soft_req, soft_apply;
    logic               start, pay_hs, last, pkt_done;
    logic               ctrl_unused;

    assign ctrl_unused = ^ctrl[31:3];

    // A soft reset waits for the packet in flight to finish so no truncated packet escapes.
    assign soft_req   = soft_pend | ctrl_r[1];
    assign start      = (state == ST_IDLE) & ctrl_r[0] & S_AXIS_TVALID & ~soft_req;
    assign pay_hs     = (state == ST_PAY) & S_AXIS_TVALID & M_AXIS_TREADY;
    assign last       = (beat_cnt == len_lat - C_LEN_W'(1));
    assign pkt_done   = pay_hs & last;
    assign soft_apply = soft_req & ((state == ST_IDLE) | pkt_done);

    vita49_ts_latch64 u_ts (
        .clk     (AXIS_ACLK),
        .rst_n   (AXIS_ARESETN),
        .tsi     (tsi),
        .tsf     (tsf),
        .capture (start),
        .tsi_lat (tsi_lat),
        .tsf_lat (tsf_lat)
    );

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state     <= ST_IDLE;
            ctrl_r    <= '0;
            len_r     <= '0;
            sid_r     <= '0;
            len_lat   <= '0;
            sid_lat   <= '0;
            beat_cnt  <= '0;
            pkt_cnt   <= '0;
            sent_cnt  <= '0;
            soft_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctrl_r    <= ctrl[2:0];
            len_r     <= pkt_len;
            sid_r     <= stream_id;
            soft_pend <= (soft_pend | ctrl_r[1]) & ~soft_apply;
            if (start) begin
                len_lat  <= (len_r == '0) ? C_LEN_W'(1) : len_r;
                sid_lat  <= sid_r;
                beat_cnt <= '0;
            end else if (pay_hs) begin
                beat_cnt <= beat_cnt + C_LEN_W'(1);
            end
            // Clearing outranks the end-of-packet increment.
            if (ctrl_r[2] || soft_apply) begin
                pkt_cnt  <= '0;
                sent_cnt <= '0;
            end else if (pkt_done) begin
                pkt_cnt <= pkt_cnt + 4'd1;
                if (sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        M_AXIS_TDATA  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_HDR0;
            end
            ST_HDR0: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = {build_hdr(pkt_cnt, 16'(len_lat)), sid_lat};
                if (M_AXIS_TREADY) state_nxt = ST_HDR1;
            end
            ST_HDR1: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = {32'h0, tsi_lat};
                if (M_AXIS_TREADY) state_nxt = ST_HDR2;
            end
            ST_HDR2: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = tsf_lat;
                if (M_AXIS_TREADY) state_nxt = ST_PAY;
            end
            ST_PAY: begin
                M_AXIS_TDATA  = S_AXIS_TDATA;
                M_AXIS_TVALID = S_AXIS_TVALID;
                S_AXIS_TREADY = M_AXIS_TREADY;
                M_AXIS_TLAST  = last;
                if (pkt_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign M_AXIS_TSTRB = {C_AXIS_TDATA_NUM_BYTES{M_AXIS_TVALID}};
    assign status       = {sent_cnt, 8'h00, pkt_cnt, 2'b00, ctrl_r[0], state != ST_IDLE};

endmodule

// File: tb/tb_vita49_pack64_logic.sv
// Randomised bench for the VITA-49 packetiser with a packet-level reference model.
module tb_vita49_pack64_logic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata, m_tdata;
    logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic [7:0]  m_tstrb;
    logic [31:0] ctrl, stream_id, status, tsi;
    logic [11:0] pkt_len;
    logic [63:0] tsf;

    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Time ramps are pure functions of the cycle number, so the model can recompute them.
    function automatic logic [31:0] ts_i(input int c);
        return 32'h1000_0000 + 32'(c);
    endfunction
    function automatic logic [63:0] ts_f(input int c);
        return 64'hF000_0000_0000_0000 + 64'(c) * 64'd7;
    endfunction
    function automatic logic [31:0] exp_hdr(input int pc, input int len);
        return 32'h1060_0000 + 32'(pc << 16) + 32'(2 * (3 + len));
    endfunction

    assign tsi = ts_i(cyc);
    assign tsf = ts_f(cyc);

    vita49_pack64_logic dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .ctrl          (ctrl),
        .pkt_len       (pkt_len),
        .stream_id     (stream_id),
        .status        (status),
        .tsi           (tsi),
        .tsf           (tsf)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Knobs set by the main sequence.
    int gen_target = 0;
    int valid_pct = 100;
    int ready_pct = 100;
    int cur_len = 4;
    logic [31:0] cur_sid = 32'hA5A5_0001;
    int soft_req = 0;
    int clr_req = 0;

    // Generator state.
    int gen_sent = 0;
    int rise_q[$];

    // Model state.
    logic [63:0] in_q[$];
    logic [63:0] hdr_log[$];
    logic [31:0] tsi_log[$];
    int hcyc_log[$];
    int cur_idx = 0;
    int m_pcnt = 0;
    int m_sent = 0;
    int soft_ack = 0;
    int clr_ack = 0;
    int hdr_cyc = 0;
    bit hdr_noted = 0;
    bit prev_stall = 0;
    logic [63:0] prev_data = '0;
    int in_cnt = 0;
    int pay_cnt = 0;

    initial begin : gen
        bit hs;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs || !s_tvalid) begin
                if (gen_sent < gen_target && $urandom_range(99) < valid_pct) begin
                    s_tdata = {$urandom(), $urandom()};
                    if (!s_tvalid) rise_q.push_back(cyc);
                    s_tvalid = 1'b1;
                    gen_sent++;
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin : monitor
        int eff_len;
        logic [63:0] exp_d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_q.delete();
                cur_idx = 0; m_pcnt = 0; m_sent = 0;
                hdr_noted = 0; prev_stall = 0;
                soft_ack = soft_req; clr_ack = clr_req;
            end else begin
                if (clr_ack != clr_req) begin
                    m_pcnt = 0; m_sent = 0; clr_ack = clr_req;
                end
                if (s_tvalid && s_tready) begin
                    in_q.push_back(s_tdata);
                    in_cnt++;
                end
                if (m_tvalid) begin
                    chk("tstrb", 64'(m_tstrb), 64'hFF);
                    if (prev_stall) chk("hdr_hold", m_tdata, prev_data);
                    if (cur_idx == 0 && !hdr_noted) begin
                        hdr_cyc = cyc; hdr_noted = 1;
                    end
                    eff_len = (cur_len == 0) ? 1 : cur_len;
                    prev_stall = !m_tready && cur_idx < 3;
                    prev_data  = m_tdata;
                    if (m_tready) begin
                        case (cur_idx)
                            0: exp_d = {exp_hdr(m_pcnt, eff_len), cur_sid};
                            1: exp_d = {32'h0, ts_i(hdr_cyc - 3)};
                            2: exp_d = ts_f(hdr_cyc - 3);
                            default: begin
                                if (in_q.size() == 0) begin
                                    chk("payload_underflow", 64'(0), 64'(1));
                                    exp_d = 'x;
                                end else begin
                                    exp_d = in_q.pop_front();
                                end
                                pay_cnt++;
                            end
                        endcase
                        if (exp_d !== 'x) chk($sformatf("beat%0d", cur_idx), m_tdata, exp_d);
                        if (cur_idx == 0) begin
                            hdr_log.push_back(m_tdata);
                            hcyc_log.push_back(hdr_cyc);
                        end
                        if (cur_idx == 1) tsi_log.push_back(m_tdata[31:0]);
                        if (cur_idx == eff_len + 2) begin
                            chk("tlast_end", 64'(m_tlast), 64'(1));
                            if (soft_ack != soft_req) begin
                                m_pcnt = 0; m_sent = 0; soft_ack = soft_req;
                            end else begin
                                m_pcnt = (m_pcnt + 1) % 16;
                                if (m_sent < 65535) m_sent++;
                            end
                            cur_idx = 0; hdr_noted = 0;
                        end else begin
                            chk("tlast_mid", 64'(m_tlast), 64'(0));
                            cur_idx++;
                        end
                    end
                end else begin
                    prev_stall = 0;
                end
            end
        end
    end

    function automatic logic [31:0] exp_status(input bit en);
        return {16'(m_sent), 8'h00, 4'(m_pcnt), 2'b00, en, 1'b0};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk);
            #1;
            if (gen_sent == gen_target && !s_tvalid && !status[0] && cur_idx == 0) ok = 1;
        end
        if (!ok) chk({"timeout_", name}, 64'(0), 64'(1));
        cycles(2);
    endtask

    task automatic wait_idx(input int target, input int max, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk);
            #1;
            if (cur_idx == target) ok = 1;
        end
        if (!ok) chk({"timeout_", name}, 64'(0), 64'(1));
    endtask

    initial begin : main
        int b, r;
        rst_n = 1'b0;
        ctrl = 32'h0;
        pkt_len = 12'd4;
        stream_id = 32'hA5A5_0001;
        cycles(3);
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_mvalid", 64'(m_tvalid), 64'(0));
        chk("rst_sready", 64'(s_tready), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        rst_n = 1'b1;
        cycles(3);

        // Timestamp capture, two back-to-back packets.
        ctrl = 32'h1;
        cycles(3);
        b = hdr_log.size();
        gen_target += 8;
        wait_done(200, "ts");
        r = rise_q[rise_q.size() - 1];
        chk("ts_npkt", 64'(hdr_log.size() - b), 64'(2));
        if (hdr_log.size() >= b + 2) begin
            chk("ts_hdr0", hdr_log[b], 64'h1060000E_A5A50001);
            chk("ts_hdr1", hdr_log[b + 1], 64'h1061000E_A5A50001);
            chk("ts_tsi", 64'(tsi_log[b]), 64'(32'h1000_0000 + 32'(r - 2)));
            chk("ts_latency", 64'(hcyc_log[b]), 64'(r + 1));
        end
        chk("ts_status", 64'(status), 64'h0002_0022);

        // Backpressure with random gaps.
        b = hdr_log.size();
        valid_pct = 60; ready_pct = 50;
        gen_target += 40;
        wait_done(3000, "bp");
        valid_pct = 100; ready_pct = 100;
        chk("bp_npkt", 64'(hdr_log.size() - b), 64'(10));
        chk("bp_lossless", 64'(pay_cnt), 64'(in_cnt));
        chk("bp_status", 64'(status), 64'(exp_status(1)));

        // Enable dropped during payload beat 2.
        b = hdr_log.size();
        gen_target += 8;
        wait_idx(4, 200, "en_beat2");
        ctrl = 32'h0;
        cycles(20);
        chk("en_npkt", 64'(hdr_log.size() - b), 64'(1));
        chk("en_sready", 64'(s_tready), 64'(0));
        chk("en_status", 64'(status), 64'(exp_status(0)));

        // Soft reset at HDR1 is deferred to the packet end.
        b = hdr_log.size();
        ctrl = 32'h1;
        wait_idx(1, 200, "soft_hdr1");
        ctrl = 32'h2;
        soft_req++;
        cycles(1);
        ctrl = 32'h0;
        wait_done(200, "soft");
        chk("soft_npkt", 64'(hdr_log.size() - b), 64'(1));
        chk("soft_status", 64'(status), 64'(0));

        // pkt_len=0 and pkt_cnt wrap.
        pkt_len = 12'd0; cur_len = 0;
        cycles(2);
        ctrl = 32'h1;
        cycles(3);
        b = hdr_log.size();
        gen_target += 17;
        wait_done(600, "cnt");
        chk("cnt_npkt", 64'(hdr_log.size() - b), 64'(17));
        if (hdr_log.size() >= b + 17) begin
            chk("cnt_hdr_first", hdr_log[b], 64'h10600008_A5A50001);
            chk("cnt_hdr_wrap", hdr_log[b + 16], 64'h10600008_A5A50001);
        end
        chk("cnt_status", 64'(status), 64'h0011_0012);
        ctrl = 32'h5;
        clr_req++;
        cycles(1);
        ctrl = 32'h1;
        cycles(3);
        chk("clr_status", 64'(status), 64'h0000_0002);

        // Asynchronous reset mid-payload.
        pkt_len = 12'd4; cur_len = 4;
        cycles(2);
        gen_target += 5;
        wait_idx(4, 200, "arst_beat2");
        #2;
        rst_n = 1'b0;
        ctrl = 32'h0;
        #1;
        chk("arst_mvalid", 64'(m_tvalid), 64'(0));
        chk("arst_sready", 64'(s_tready), 64'(0));
        chk("arst_tlast", 64'(m_tlast), 64'(0));
        chk("arst_tdata", m_tdata, 64'(0));
        chk("arst_tstrb", 64'(m_tstrb), 64'(0));
        chk("arst_status", 64'(status), 64'(0));
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        b = hdr_log.size();
        ctrl = 32'h1;
        wait_done(200, "arst");
        chk("arst_npkt", 64'(hdr_log.size() - b), 64'(1));
        if (hdr_log.size() > b) chk("arst_hdr", hdr_log[b], 64'h1060000E_A5A50001);
        chk("arst_status_after", 64'(status), 64'h0001_0012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
